// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between the CPU MEM stage and the debug/loader port.
// Starvation-counted priority, a debug lock mode for atomic bursts, and read-data return routing.
module dmem_arbiter #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_stall,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_rvalid,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic                  dbg_lock,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   output logic                  dbg_gnt,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic                  dbg_rvalid,
   output logic                  mem_w,
   output logic                  mem_r,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_CPU  = 2'd0,
      ST_DBG  = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

   state_t                state, state_nxt;
   logic                  cpu_gnt;
   logic [3:0]            starve_cnt;
   logic                  rd_pending;
   logic                  rd_owner;
   logic [DATA_WIDTH-1:0] cpu_rdata_q;
   logic [DATA_WIDTH-1:0] dbg_rdata_q;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_CPU;
      else     state <= state_nxt;
   end

   // ST_DBG lasts exactly one cycle: a pending DBG request is always granted there.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_CPU: begin
            if (cpu_gnt && dbg_req && starve_cnt == STARVE_LAST) state_nxt = ST_DBG;
            else if (dbg_gnt && dbg_lock)                           state_nxt = ST_LOCK;
         end
         ST_DBG:  state_nxt = (dbg_gnt && dbg_lock) ? ST_LOCK : ST_CPU;
         ST_LOCK: if (!dbg_lock) state_nxt = ST_CPU;
         default: state_nxt = ST_CPU;
      endcase
   end

   always_comb begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (!rst) begin
         case (state)
            ST_CPU: begin
               cpu_gnt = cpu_req;
               dbg_gnt = dbg_req & ~cpu_req;
            end
            ST_DBG: begin
               dbg_gnt = dbg_req;
               cpu_gnt = cpu_req & ~dbg_req;
            end
            ST_LOCK: dbg_gnt = dbg_req;
            default: begin
               cpu_gnt = 1'b0;
               dbg_gnt = 1'b0;
            end
         endcase
      end
      cpu_stall = cpu_req & ~cpu_gnt & ~rst;
      mem_r     = (cpu_gnt & ~cpu_we) | (dbg_gnt & ~dbg_we);
      mem_w     = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_gnt) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (dbg_gnt) begin
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         starve_cnt <= '0;
      else if (dbg_gnt || !dbg_req)
         starve_cnt <= '0;
      else if (state == ST_CPU && cpu_gnt && starve_cnt != 4'hF)
         starve_cnt <= starve_cnt + 4'd1;
   end

   // Read return: owner sees live mem_rdata, the other port keeps its last delivered word.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pending  <= 1'b0;
         rd_owner    <= 1'b0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         rd_pending <= mem_r;
         rd_owner   <= dbg_gnt;
         if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
         if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
      end
   end

   always_comb begin
      cpu_rvalid = rd_pending & ~rd_owner & ~rst;
      dbg_rvalid = rd_pending & rd_owner & ~rst;
      cpu_rdata  = '0;
      dbg_rdata  = '0;
      if (!rst) begin
         cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
         dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_q;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle grant checks plus a read-return scoreboard.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [7:0]  cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_stall;
   logic [31:0] cpu_rdata;
   logic        cpu_rvalid;
   logic        dbg_req, dbg_we, dbg_lock;
   logic [7:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_gnt;
   logic [31:0] dbg_rdata;
   logic        dbg_rvalid;
   logic        mem_w, mem_r;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;

   logic [31:0] mem [256];
   logic [31:0] cpu_q[$];
   logic [31:0] dbg_q[$];
   int          checks = 0;
   int          passes = 0;

   dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
      .mem_w(mem_w), .mem_r(mem_r), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Write-first data memory; preset words reload during reset.
   always @(posedge clk) begin
      if (rst) begin
         mem[8'h10] <= 32'hDEADBEEF;
         mem[8'h05] <= 32'h000000AA;
         mem[8'h06] <= 32'h000000BB;
      end else begin
         if (mem_w) mem[mem_addr] <= mem_wdata;
         if (mem_r) mem_rdata <= mem[mem_addr];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (cpu_rvalid) begin
         if (cpu_q.size() == 0) chk("cpu_rvalid_spurious", 64'(cpu_rvalid), 64'd0);
         else                   chk("cpu_rdata", 64'(cpu_rdata), 64'(cpu_q.pop_front()));
      end
      if (dbg_rvalid) begin
         if (dbg_q.size() == 0) chk("dbg_rvalid_spurious", 64'(dbg_rvalid), 64'd0);
         else                   chk("dbg_rdata", 64'(dbg_rdata), 64'(dbg_q.pop_front()));
      end
   end

   task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic dl, input logic [7:0] da,
                        input logic [31:0] dd);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dbg_req = dr; dbg_we = dw; dbg_lock = dl; dbg_addr = da; dbg_wdata = dd;
   endtask

   // Checks {cpu_stall, dbg_gnt, mem_r, mem_w, mem_addr, mem_wdata} mid-cycle, then advances.
   task automatic step(input string nm, input logic stall, input logic dg, input logic r,
                       input logic w, input logic [7:0] a, input logic [31:0] wd);
      @(negedge clk);
      chk(nm, 64'({cpu_stall, dbg_gnt, mem_r, mem_w, mem_addr, mem_wdata}),
              64'({stall, dg, r, w, a, wd}));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      drive(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset_rvalid", 64'({cpu_rvalid, dbg_rvalid}), 64'd0);
      chk("reset_rdata", 64'({cpu_rdata, dbg_rdata}), 64'd0);
      step("reset_strobes", 0, 0, 0, 0, 8'h00, 0);
      rst = 1'b0;

      // CPU read with no contention
      drive(1, 0, 8'h10, 0, 0, 0, 0, 8'h00, 0);
      cpu_q.push_back(32'hDEADBEEF);
      step("t1_read", 0, 0, 1, 0, 8'h10, 0);
      drive(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
      step("t1_idle", 0, 0, 0, 0, 8'h00, 0);
      chk("t1_rdata_hold", 64'(cpu_rdata), 64'h0000_0000_DEAD_BEEF);

      // Write then read the same address on consecutive grants
      drive(1, 1, 8'h30, 32'h55, 0, 0, 0, 8'h00, 0);
      step("t6_write", 0, 0, 0, 1, 8'h30, 32'h55);
      drive(1, 0, 8'h30, 0, 0, 0, 0, 8'h00, 0);
      cpu_q.push_back(32'h55);
      step("t6_read", 0, 0, 1, 0, 8'h30, 0);
      drive(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
      step("t6_idle", 0, 0, 0, 0, 8'h00, 0);

      // Alternating owners, no cross-delivery
      drive(0, 0, 8'h00, 0, 1, 0, 0, 8'h05, 0);
      dbg_q.push_back(32'hAA);
      step("t4_dbg_read", 0, 1, 1, 0, 8'h05, 0);
      drive(1, 0, 8'h06, 0, 0, 0, 0, 8'h00, 0);
      cpu_q.push_back(32'hBB);
      step("t4_cpu_read", 0, 0, 1, 0, 8'h06, 0);
      drive(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
      step("t4_idle", 0, 0, 0, 0, 8'h00, 0);

      // Continuous conflict: DBG gets every fifth cycle
      drive(1, 1, 8'h40, 32'h11, 1, 0, 0, 8'h05, 0);
      for (int c = 0; c < 10; c++) begin
         if (c == 4 || c == 9) begin
            dbg_q.push_back(32'hAA);
            step($sformatf("t2_c%0d", c), 1, 1, 1, 0, 8'h05, 0);
         end else begin
            step($sformatf("t2_c%0d", c), 0, 0, 0, 1, 8'h40, 32'h11);
         end
      end
      drive(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
      step("t2_idle", 0, 0, 0, 0, 8'h00, 0);

      // Locked debug burst against a waiting CPU
      drive(1, 0, 8'h10, 0, 1, 1, 1, 8'h20, 32'h1);
      for (int c = 0; c < 4; c++) begin
         cpu_q.push_back(32'hDEADBEEF);
         step($sformatf("t3_cpu_c%0d", c), 0, 0, 1, 0, 8'h10, 0);
      end
      step("t3_dbg_w0", 1, 1, 0, 1, 8'h20, 32'h1);
      drive(1, 0, 8'h10, 0, 1, 1, 1, 8'h21, 32'h2);
      step("t3_dbg_w1", 1, 1, 0, 1, 8'h21, 32'h2);
      drive(1, 0, 8'h10, 0, 1, 1, 1, 8'h22, 32'h3);
      step("t3_dbg_w2", 1, 1, 0, 1, 8'h22, 32'h3);
      drive(1, 0, 8'h10, 0, 0, 0, 1, 8'h00, 0);
      step("t3_lock_idle", 1, 0, 0, 0, 8'h00, 0);
      drive(1, 0, 8'h10, 0, 0, 0, 0, 8'h00, 0);
      step("t3_lock_exit", 1, 0, 0, 0, 8'h00, 0);
      cpu_q.push_back(32'hDEADBEEF);
      step("t3_cpu_after", 0, 0, 1, 0, 8'h10, 0);
      drive(0, 0, 8'h00, 0, 1, 0, 0, 8'h21, 0);
      dbg_q.push_back(32'h2);
      step("t3_readback", 0, 1, 1, 0, 8'h21, 0);
      drive(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
      step("t3_idle", 0, 0, 0, 0, 8'h00, 0);

      // dbg_lock without dbg_req leaves the CPU free
      drive(1, 0, 8'h06, 0, 0, 0, 1, 8'h00, 0);
      cpu_q.push_back(32'hBB);
      step("lock_noreq_0", 0, 0, 1, 0, 8'h06, 0);
      drive(1, 0, 8'h05, 0, 0, 0, 1, 8'h00, 0);
      cpu_q.push_back(32'hAA);
      step("lock_noreq_1", 0, 0, 1, 0, 8'h05, 0);
      drive(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
      step("lock_noreq_idle", 0, 0, 0, 0, 8'h00, 0);

      // Reset during an outstanding read discards it
      drive(1, 0, 8'h10, 0, 0, 0, 0, 8'h00, 0);
      step("t5_read", 0, 0, 1, 0, 8'h10, 0);
      rst = 1'b1;
      drive(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
      @(negedge clk);
      chk("t5_rst_rvalid", 64'({cpu_rvalid, dbg_rvalid}), 64'd0);
      step("t5_rst_strobes", 0, 0, 0, 0, 8'h00, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("t5_post_rvalid", 64'({cpu_rvalid, dbg_rvalid}), 64'd0);
      chk("t5_post_rdata", 64'({cpu_rdata, dbg_rdata}), 64'd0);
      @(posedge clk); #1;
      drive(1, 1, 8'h41, 32'h77, 1, 0, 0, 8'h05, 0);
      step("t5_cpu_first", 0, 0, 0, 1, 8'h41, 32'h77);
      drive(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
      step("t5_idle", 0, 0, 0, 0, 8'h00, 0);

      chk("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
      chk("dbg_q_drained", 64'(dbg_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port).
- Sits between the EX/MEM pipeline registers and data_memory.
- Arbitrates each cycle and stalls the pipeline when the CPU loses.
- Routes the one-cycle-latency read data back to whichever port issued the read.
- Uses starvation-counted priority plus a debug lock mode for atomic multi-word debug bursts.

Parameters:
DATA_WIDTH, 32, data word width (matches RISC_V_DATA_WIDTH)
ADDR_WIDTH, 8, word address width (matches DATA_MEMORY_ADDRESS_WIDTH)
STARVE_LIMIT, 4, consecutive CPU wins while DBG waits before DBG gets one guaranteed grant; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request (mem_r | mem_w from EX/MEM)
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_WIDTH  CPU word address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_stall  out  1  CPU request not granted this cycle; freeze PC, IF/ID, ID/EX, EX/MEM
cpu_rdata  out  DATA_WIDTH  read data for CPU
cpu_rvalid  out  1  cpu_rdata valid (one cycle after granted read)
dbg_req  in  1  debug access request
dbg_we  in  1  1 = write, 0 = read
dbg_lock  in  1  request exclusive ownership while asserted
dbg_addr  in  ADDR_WIDTH  debug word address
dbg_wdata  in  DATA_WIDTH  debug write data
dbg_gnt  out  1  debug request granted this cycle
dbg_rdata  out  DATA_WIDTH  read data for debug
dbg_rvalid  out  1  dbg_rdata valid
mem_w  out  1  memory write strobe
mem_r  out  1  memory read strobe
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_r

Behaviour:

Grant decision:
- Combinational from the current state and this cycle's requests.
- Only one of cpu_gnt (internal) and dbg_gnt is high per cycle.
- Memory strobes go out the same cycle as the grant:
  - mem_r = gnt & ~we
  - mem_w = gnt & we
- mem_addr and mem_wdata are muxed from the granted port; they are 0 when idle.

Derived outputs:
- cpu_stall = cpu_req & ~cpu_gnt.
- The requester holds req, we, addr and wdata stable until granted.

States:
- ST_CPU: CPU wins on conflict. Each cycle with cpu_gnt & dbg_req, starve_cnt increments. On starve_cnt == STARVE_LIMIT-1 with another conflict win, go to ST_DBG.
- ST_DBG: DBG wins on conflict.
  - After one DBG grant: go to ST_LOCK if dbg_lock is high, else ST_CPU.
  - If dbg_req drops before being granted: go to ST_CPU.
  - starve_cnt clears on leaving.
- ST_LOCK: only DBG is granted; cpu_stall = cpu_req. Stays while dbg_lock is high. When dbg_lock falls, go to ST_CPU next cycle; that cycle still uses LOCK rules.

Entering lock:
- From ST_CPU, a DBG grant (no CPU conflict) with dbg_lock high goes to ST_LOCK.
- starve_cnt clears on any DBG grant and whenever dbg_req is low.
- starve_cnt is 4 bits and saturates; it never wraps.

Read return:
- rd_owner and rd_pending are registered on each granted read.
- Next cycle, the owner's rvalid = 1 and its rdata = mem_rdata.
- The other port's rdata holds its last value and its rvalid = 0.
- Back-to-back reads alternating owners return in issue order, one per cycle.
- Write-then-read to the same address on consecutive grants returns the new data; memory write-first is required of data_memory.

Reset:
- State ST_CPU, starve_cnt 0, rd_pending 0.
- cpu_rvalid = dbg_rvalid = 0; cpu_rdata = dbg_rdata = 0.
- dbg_gnt = 0, mem_r = mem_w = 0, mem_addr = 0, mem_wdata = 0, cpu_stall = 0.
- Reset during an outstanding read discards it; no rvalid is issued after reset.

Boundaries:
- No requests: all strobes 0, state held (ST_DBG falls back to ST_CPU).
- dbg_lock without dbg_req: no effect.
- In ST_LOCK with dbg_req low: memory is idle, but the CPU still stalls.
- STARVE_LIMIT = 1: DBG wins every second conflict cycle.

Test Plan:
1. Reset, then cpu_req=1 read addr 0x10 (mem holds 0xDEADBEEF) -> mem_r=1 addr 0x10 same cycle; cycle+1 cpu_rvalid=1, cpu_rdata=0xDEADBEEF; cpu_stall=0 throughout.
2. cpu_req and dbg_req both high continuously, STARVE_LIMIT=4 -> CPU granted cycles 0-3 (cpu_stall=0), dbg_gnt=1 cycle 4 with cpu_stall=1, CPU granted cycles 5-8, dbg_gnt cycle 9.
3. dbg_lock=1, dbg writes 0x1,0x2,0x3 to addr 0x20-0x22 while cpu_req=1 -> dbg_gnt on 3 consecutive cycles, cpu_stall=1 until dbg_lock falls, CPU granted the cycle after ST_LOCK exit.
4. Alternating grants: DBG read 0x05 (=0xAA) then CPU read 0x06 (=0xBB) -> dbg_rvalid with 0xAA next cycle, then cpu_rvalid with 0xBB; no cross-delivery.
5. Granted CPU read, rst asserted the next cycle -> cpu_rvalid stays 0; state ST_CPU, all outputs 0.
6. CPU write 0x55 to addr 0x30, CPU read addr 0x30 next cycle -> cpu_rvalid with 0x55; starve_cnt stays 0 since dbg_req=0.
